grid_pixel_gen: RTL

Pixel source stage that sits directly upstream of the VGA output pins, consuming the 640x480 scan counters and sync signals from the VGA timing generator and producing the 12-bit final pixel. Holds a 20x15 grid of 32x32-pixel cells, each storing a 4-bit colour index. The grid is written through a valid/ready port and auto-cleared after reset. Sync signals are delayed to stay aligned with the pixel pipeline.

---
 rtl/grid_pixel_gen_if.sv | 25 ++
 rtl/grid_pixel_gen.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/grid_pixel_gen_if.sv
// Cell-write port of grid_pixel_gen: valid/ready handshake carrying a
// column/row target and a 4-bit colour index.
interface grid_pixel_gen_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_col;
  logic [4:0] wr_row;
  logic [3:0] wr_color;

  modport master (
    output wr_valid,
    output wr_col,
    output wr_row,
    output wr_color,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_col,
    input  wr_row,
    input  wr_color,
    output wr_ready
  );
endinterface

// File: rtl/grid_pixel_gen.sv
// grid_pixel_gen: final pixel source ahead of the VGA pins. Holds a grid of
// 32x32-pixel cells (4-bit colour index each), cleared after reset, written
// through a valid/ready port and read by a two-stage pixel-rate pipeline with
// matching sync delay.
// Optional feature: define GRID_LINES_EN to draw white lines on the first
// row/column of every cell.
module grid_pixel_gen #(
  parameter int CELL_LOG2 = 5,
  parameter int GRID_COLS = 20,
  parameter int GRID_ROWS = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic               hsync_in,
  input  logic               vsync_in,
  grid_pixel_gen_if.slave    wr,
  output logic [11:0]        pixel,
  output logic               hsync,
  output logic               vsync,
  output logic               init_done
);

  localparam int CELLS  = GRID_COLS * GRID_ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(GRID_COLS);
  localparam logic [4:0]        COLS_5    = 5'(GRID_COLS);
  localparam logic [4:0]        ROWS_5    = 5'(GRID_ROWS);
  localparam logic [9:0]        H_ACTIVE  = 10'd640;
  localparam logic [9:0]        V_ACTIVE  = 10'd480;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [3:0]        mem [CELLS];

  // Grey ramp: replicate the cell index into R, G and B.
  function automatic logic [11:0] grey_expand(input logic [3:0] c);
    return {c, c, c};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  // Next state: leave INIT once the last cell has been cleared
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && clr_cnt == LAST_ADDR) state_nxt = ST_RUN;
  end

  // Outputs decoded from state only
  always_comb begin
    wr.wr_ready = (state == ST_RUN);
    init_done   = (state == ST_RUN);
  end

  // Clear counter walks every cell once per clk while in INIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         clr_cnt <= '0;
    else if (state == ST_INIT && clr_cnt != LAST_ADDR) clr_cnt <= clr_cnt + 1'b1;
  end

  // Cell write port: clearing in INIT, host writes in RUN (out-of-range dropped)
  logic              wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  assign wr_in_range = (wr.wr_col < COLS_5) && (wr.wr_row < ROWS_5);
  assign wr_addr     = ADDR_W'(wr.wr_row) * COLS_A + ADDR_W'(wr.wr_col);

  always_ff @(posedge clk) begin
    if (state == ST_INIT)
      mem[clr_cnt] <= 4'h0;
    else if (wr.wr_valid && wr_in_range)
      mem[wr_addr] <= wr.wr_color;
  end

  // S1 combinational decode; inactive positions park on address 0 so the
  // S2 read never leaves the array
  logic              active_c;
  logic [ADDR_W-1:0] rd_addr_c;
  assign active_c  = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
  assign rd_addr_c = active_c
                   ? ADDR_W'(v_cnt >> CELL_LOG2) * COLS_A + ADDR_W'(h_cnt >> CELL_LOG2)
                   : '0;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              hsync_p1, vsync_p1;
`ifdef GRID_LINES_EN
  logic              line_p1;
`endif

  // ---- S1: register scan decode and syncs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
`ifdef GRID_LINES_EN
      line_p1  <= 1'b0;
`endif
    end else if (pix_en) begin
      vld_p1   <= active_c;
      addr_p1  <= rd_addr_c;
      hsync_p1 <= hsync_in;
      vsync_p1 <= vsync_in;
`ifdef GRID_LINES_EN
      line_p1  <= (h_cnt[CELL_LOG2-1:0] == '0) || (v_cnt[CELL_LOG2-1:0] == '0);
`endif
    end
  end

  // ---- S2: cell read, colour mapping, blanking during INIT ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      hsync <= hsync_p1;
      vsync <= vsync_p1;
      if (state != ST_RUN || !vld_p1)
        pixel <= 12'h000;
`ifdef GRID_LINES_EN
      else if (line_p1)
        pixel <= 12'hFFF;
`endif
      else
        pixel <= grey_expand(mem[addr_p1]);
    end
  end

endmodule
